// File: rtl/sram_frame_reader.sv
// sram_frame_reader: streams WORD_COUNT contiguous 32-bit words out of the
// SRAM frame buffer through the arbiter's R1 read port. Requests are issued
// only when a FIFO slot is reserved for the response, so no response is ever
// dropped.
module sram_frame_reader #(
  parameter int          WORD_COUNT = 240000,
  parameter logic [17:0] BASE_ADDR  = 18'h00000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        start_ack,
  output logic        done,
  input  logic        done_ack,
  output logic [17:0] addr,
  output logic        addr_valid,
  input  logic        addr_ready,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last
);

  // Counters are one bit wider than an SRAM address so WORD_COUNT = 2^18 fits.
  localparam int            CW       = 19;
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] WORDS    = CW'(WORD_COUNT);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_COUNT - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic          start_fire;
  logic [CW-1:0] req_cnt;    // addresses accepted by the arbiter
  logic [CW-1:0] rsp_cnt;    // responses written into the FIFO
  logic [CW-1:0] out_cnt;    // words popped by the consumer
  logic [CW-1:0] in_flight;
  logic          addr_fire, push, pop, fifo_empty;
  logic [31:0]   mem [FIFO_DEPTH];

  // The low bits of the push/pop counts double as FIFO write/read pointers,
  // since both counters are cleared together at the start of every run.
  assign in_flight  = req_cnt - out_cnt;
  assign fifo_empty = (rsp_cnt == out_cnt);

  assign addr_valid = (state == RUN) && (req_cnt < WORDS) && (in_flight < DEPTH);
  assign addr       = BASE_ADDR + req_cnt[17:0];
  assign data_ready = (state == RUN);
  assign dout_valid = !fifo_empty;
  assign dout       = fifo_empty ? '0 : mem[out_cnt[AW-1:0]];
  assign dout_last  = dout_valid && (out_cnt == LAST_IDX);
  assign done       = (state == DONE);

  assign addr_fire = addr_valid && addr_ready;
  // A response with no outstanding request has no reserved slot; drop it.
  assign push      = data_valid && data_ready && (rsp_cnt != req_cnt);
  assign pop       = dout_valid && dout_ready;

  // Next-state decode for the IDLE/RUN/DONE run sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_next = state;
    start_fire = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_next = RUN;
        start_fire = 1'b1;
      end
      RUN:  if (pop && dout_last) state_next = DONE;
      DONE: if (done_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and the one-cycle start acknowledge.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (reset) begin
      state     <= IDLE;
      start_ack <= 1'b0;
    end else begin
      state     <= state_next;
      start_ack <= start_fire;
    end
  end

  // Request, response and output counters; cleared when a run is accepted.
  always_ff @(posedge clock) begin
    if (reset || start_fire) begin
      req_cnt <= '0;
      rsp_cnt <= '0;
      out_cnt <= '0;
    end else begin
      if (addr_fire) req_cnt <= req_cnt + CW'(1);
      if (push)      rsp_cnt <= rsp_cnt + CW'(1);
      if (pop)       out_cnt <= out_cnt + CW'(1);
    end
  end

  // Response storage.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; emptiness comes
    // from the counters, and dout is forced to zero while the FIFO is empty.
    if (push) mem[rsp_cnt[AW-1:0]] <= data;
  end

`ifndef SYNTHESIS
  // A response arriving with nothing outstanding means the arbiter misbehaved.
  stray_response: assert property (@(posedge clock) disable iff (reset)
    (data_valid && data_ready) |-> (rsp_cnt != req_cnt));
`endif

endmodule
